// File: rtl/wb_sequencer_if.sv
// Request and register-file write-port bundle for the write-back sequencer.
// The master is the upstream pipeline; the slave is the sequencer itself.
interface wb_sequencer_if #(
  parameter int pw = 4
);
  logic          alu_valid;
  logic [pw:0]   alu_dest;
  logic [7:0]    alu_data;
  logic          ld_valid;
  logic [pw:0]   ld_dest;
  logic [7:0]    ld_data;
  logic          swap_req;
  logic [pw:0]   swap_addrA;
  logic [pw:0]   swap_addrB;
  logic [7:0]    swap_datA;
  logic [7:0]    swap_datB;
  logic          wr_en;
  logic [pw:0]   wr_addr;
  logic [7:0]    dat_out;
  logic          stall;
  logic          empty;
  logic          err;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ld_valid, ld_dest, ld_data,
    output swap_req, swap_addrA, swap_addrB, swap_datA, swap_datB,
    input  wr_en, wr_addr, dat_out, stall, empty, err
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ld_valid, ld_dest, ld_data,
    input  swap_req, swap_addrA, swap_addrB, swap_datA, swap_datB,
    output wr_en, wr_addr, dat_out, stall, empty, err
  );
endinterface

// File: rtl/wb_sequencer.sv
// Write-back sequencer: queues ALU, load and SWAP writes and issues at most
// one registered register-file write per cycle through a single write port.
module wb_sequencer #(
  parameter int pw    = 4,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  wb_sequencer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [pw:0] addr;
    logic [7:0]  data;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en_q, wr_en_d;
  logic [pw:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      dat_out_q, dat_out_d;
  logic            err_q, err_d;

  logic            stall_s;
  logic            any_req_s;
  logic [1:0]      n_in_s;
  entry_t          e0_s, e1_s, head_s;
  logic [CW:0]     total_s;
  logic [CW:0]     next_cnt_s;
  logic            pop_s;
  logic [AW-1:0]   wr_ptr_p1_s;

  assign stall_s = (count_q == CW'(DEPTH));

  // Next-state: classify the request, update the queue, select the popped entry.
  always_comb begin
    any_req_s   = bus.alu_valid | bus.ld_valid | bus.swap_req;
    n_in_s      = 2'd0;
    e0_s        = '0;
    e1_s        = '0;
    err_d       = err_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_p1_s = wr_ptr_q + AW'(1);

    if (any_req_s && stall_s) begin
      err_d = 1'b1;
    end else if (bus.swap_req) begin
      // Each register receives the other's old value; ALU/load lose the collision.
      n_in_s = 2'd2;
      e0_s   = '{addr: bus.swap_addrA, data: bus.swap_datB};
      e1_s   = '{addr: bus.swap_addrB, data: bus.swap_datA};
      if (bus.alu_valid || bus.ld_valid) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (bus.ld_valid && bus.alu_valid) begin
      n_in_s = 2'd2;
      e0_s   = '{addr: bus.ld_dest,  data: bus.ld_data};
      e1_s   = '{addr: bus.alu_dest, data: bus.alu_data};
    end else if (bus.ld_valid) begin
      n_in_s = 2'd1;
      e0_s   = '{addr: bus.ld_dest,  data: bus.ld_data};
    end else if (bus.alu_valid) begin
      n_in_s = 2'd1;
      e0_s   = '{addr: bus.alu_dest, data: bus.alu_data};
    end else begin
      n_in_s = 2'd0;
    end

    total_s    = {1'b0, count_q} + (CW+1)'(n_in_s);
    pop_s      = (total_s != '0);
    next_cnt_s = total_s - {{CW{1'b0}}, pop_s};
    count_d    = next_cnt_s[CW-1:0];

    // With an empty queue the first new entry bypasses storage entirely.
    if (count_q != CW'(0)) begin
      head_s = fifo_q[rd_ptr_q];
      if (n_in_s != 2'd0) begin
        fifo_d[wr_ptr_q] = e0_s;
      end else begin
        fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
      end
      if (n_in_s == 2'd2) begin
        fifo_d[wr_ptr_p1_s] = e1_s;
      end else begin
        fifo_d[wr_ptr_p1_s] = fifo_d[wr_ptr_p1_s];
      end
      wr_ptr_d = wr_ptr_q + AW'(n_in_s);
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      head_s = e0_s;
      if (n_in_s == 2'd2) begin
        fifo_d[wr_ptr_q] = e1_s;
        wr_ptr_d         = wr_ptr_p1_s;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      rd_ptr_d = rd_ptr_q;
    end

    wr_en_d = pop_s;
    if (pop_s) begin
      wr_addr_d = head_s.addr;
      dat_out_d = head_s.data;
    end else begin
      wr_addr_d = wr_addr_q;
      dat_out_d = dat_out_q;
    end
  end

  // State and output registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q    <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      dat_out_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      dat_out_q <= dat_out_d;
      err_q     <= err_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.dat_out = dat_out_q;
  assign bus.stall   = stall_s;
  assign bus.empty   = (count_q == CW'(0)) && !wr_en_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios then random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_wb_sequencer;

  localparam int PW    = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wb_sequencer_if #(.pw(PW)) bus ();

  wb_sequencer #(.pw(PW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: pending writes in order, plus last issued write.
  logic [PW+8:0] m_q [$];
  logic          m_wr_en;
  logic [PW:0]   m_addr;
  logic [7:0]    m_dat;
  logic          m_err;
  logic [7:0]    m_rf   [2**(PW+1)];
  logic [7:0]    dut_rf [2**(PW+1)];

  // Register file as written by the DUT's write port.
  always @(posedge clk) begin
    if (bus.wr_en) dut_rf[bus.wr_addr] <= bus.dat_out;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst);
    logic [PW+8:0] e;
    if (rst) begin
      m_q.delete();
      m_wr_en = 1'b0;
      m_addr  = '0;
      m_dat   = 8'h00;
      m_err   = 1'b0;
    end else begin
      if ((bus.alu_valid || bus.ld_valid || bus.swap_req) && (m_q.size() == DEPTH)) begin
        m_err = 1'b1;
      end else if (bus.swap_req) begin
        m_q.push_back({bus.swap_addrA, bus.swap_datB});
        m_q.push_back({bus.swap_addrB, bus.swap_datA});
        if (bus.alu_valid || bus.ld_valid) m_err = 1'b1;
      end else begin
        if (bus.ld_valid)  m_q.push_back({bus.ld_dest, bus.ld_data});
        if (bus.alu_valid) m_q.push_back({bus.alu_dest, bus.alu_data});
      end
      if (m_q.size() > 0) begin
        e       = m_q.pop_front();
        m_wr_en = 1'b1;
        m_addr  = e[PW+8:8];
        m_dat   = e[7:0];
        m_rf[m_addr] = m_dat;
      end else begin
        m_wr_en = 1'b0;
      end
    end
  endtask

  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    model_edge(rst);
    #1;
    check_eq("wr_en",   bus.wr_en,   m_wr_en);
    check_eq("wr_addr", bus.wr_addr, m_addr);
    check_eq("dat_out", bus.dat_out, m_dat);
    check_eq("stall",   bus.stall,   (m_q.size() == DEPTH));
    check_eq("empty",   bus.empty,   (m_q.size() == 0) && !m_wr_en);
    check_eq("err",     bus.err,     m_err);
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = 8'h00;
    bus.ld_valid  = 1'b0; bus.ld_dest  = '0; bus.ld_data  = 8'h00;
    bus.swap_req  = 1'b0; bus.swap_addrA = '0; bus.swap_addrB = '0;
    bus.swap_datA = 8'h00; bus.swap_datB = 8'h00;
  endtask

  task automatic set_alu(input logic [PW:0] d, input logic [7:0] x);
    bus.alu_valid = 1'b1; bus.alu_dest = d; bus.alu_data = x;
  endtask

  task automatic set_ld(input logic [PW:0] d, input logic [7:0] x);
    bus.ld_valid = 1'b1; bus.ld_dest = d; bus.ld_data = x;
  endtask

  task automatic set_swap(input logic [PW:0] a, input logic [PW:0] b,
                          input logic [7:0] da, input logic [7:0] db);
    bus.swap_req = 1'b1; bus.swap_addrA = a; bus.swap_addrB = b;
    bus.swap_datA = da; bus.swap_datB = db;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 2**(PW+1); i++) begin
      m_rf[i]   = 8'h00;
      dut_rf[i] = 8'h00;
    end
    idle();
    step(1'b1);
    step(1'b1);
    check_eq("rst_empty", bus.empty, 1'b1);
    check_eq("rst_wr_en", bus.wr_en, 1'b0);

    // Single ALU write with bypass latency of one edge.
    set_alu(5'd3, 8'h5A);
    step(1'b0);
    check_eq("alu_addr", bus.wr_addr, 5'd3);
    check_eq("alu_data", bus.dat_out, 8'h5A);
    idle();
    step(1'b0);
    check_eq("alu_done", bus.empty, 1'b1);

    // Load and ALU in one cycle: load goes first.
    set_ld(5'd1, 8'h11);
    set_alu(5'd2, 8'h22);
    step(1'b0);
    check_eq("pair_first", {bus.wr_addr, bus.dat_out}, {5'd1, 8'h11});
    idle();
    step(1'b0);
    check_eq("pair_second", {bus.wr_addr, bus.dat_out}, {5'd2, 8'h22});
    check_eq("pair_err", bus.err, 1'b0);

    // SWAP exchanges R4 and R7.
    set_swap(5'd4, 5'd7, 8'hAA, 8'h55);
    step(1'b0);
    check_eq("swap_first", {bus.wr_addr, bus.dat_out}, {5'd4, 8'h55});
    idle();
    step(1'b0);
    check_eq("swap_second", {bus.wr_addr, bus.dat_out}, {5'd7, 8'hAA});
    step(1'b0);
    step(1'b0);
    check_eq("rf_r4", dut_rf[4], 8'h55);
    check_eq("rf_r7", dut_rf[7], 8'hAA);

    // Pairs every cycle fill the queue; a stalled request is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      set_ld(5'(2*i + 8), 8'($urandom));
      set_alu(5'(2*i + 9), 8'($urandom));
      step(1'b0);
    end
    check_eq("fill_stall", bus.stall, 1'b1);
    check_eq("fill_err0", bus.err, 1'b0);
    set_alu(5'd30, 8'hEE);
    step(1'b0);
    check_eq("stall_err", bus.err, 1'b1);
    idle();
    for (int i = 0; i < 2*DEPTH + 2; i++) step(1'b0);
    check_eq("fill_drained", bus.empty, 1'b1);

    // SWAP colliding with ALU: only the swap is written, err is sticky.
    step(1'b1);
    set_swap(5'd5, 5'd6, 8'h12, 8'h34);
    set_alu(5'd9, 8'h99);
    step(1'b0);
    idle();
    for (int i = 0; i < 4; i++) step(1'b0);
    check_eq("coll_err", bus.err, 1'b1);
    check_eq("coll_r9", dut_rf[9], m_rf[9]);

    // Reset while three entries are pending, with a request on the reset edge.
    for (int i = 0; i < 3; i++) begin
      idle();
      set_ld(5'(i + 16), 8'($urandom));
      set_alu(5'(i + 20), 8'($urandom));
      step(1'b0);
    end
    set_alu(5'd31, 8'hC3);
    step(1'b1);
    check_eq("mid_rst_wr_en", bus.wr_en, 1'b0);
    check_eq("mid_rst_empty", bus.empty, 1'b1);
    check_eq("mid_rst_err",   bus.err,   1'b0);
    idle();
    for (int i = 0; i < 4; i++) step(1'b0);

    // Random traffic, including collisions, stalls and occasional resets.
    for (int i = 0; i < 600; i++) begin
      int r;
      idle();
      r = int'($urandom_range(0, 15));
      if (r < 2) begin
        set_swap(5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
        if (r == 0 && $urandom_range(0, 3) == 0) set_ld(5'($urandom), 8'($urandom));
      end else begin
        if ($urandom_range(0, 9) < 6) set_ld(5'($urandom), 8'($urandom));
        if ($urandom_range(0, 9) < 6) set_alu(5'($urandom), 8'($urandom));
      end
      step($urandom_range(0, 79) == 0);
    end
    idle();
    for (int i = 0; i < 2*DEPTH + 2; i++) step(1'b0);
    for (int i = 0; i < 2**(PW+1); i++) check_eq("rf_final", dut_rf[i], m_rf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
